mem_responder: RTL

Word-addressed data/instruction memory that sits on the far side of the multi-cycle controller's MemRead/MemWrite interface.
- Accepts one read or write request at a time.
- Models a configurable access latency with a down-counter FSM.
- Completes each request with a single-cycle mem_ready pulse, so the controller can hold its MEM/IF state until the access finishes.

---
 rtl/mem_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory responder for a multi-cycle controller.
// Accepts one read/write request at a time, waits LATENCY cycles, then
// completes with a single-cycle mem_ready pulse (and mem_error when the
// captured address was misaligned).
module mem_responder #(
    parameter int RAM_SIZE_BIT = 8,
    parameter int LATENCY      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        mem_error,
    output logic        busy
);

    localparam int DEPTH = 1 << RAM_SIZE_BIT;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [3:0]              r_count;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic                    r_is_write;
    logic [31:0]             r_read_data;
    logic                    r_ready;
    logic                    r_error;
    logic [31:0]             r_mem [DEPTH];

    logic                    w_accept;
    logic                    w_access;
    logic                    w_misaligned;
    logic                    w_in_range;
    logic [RAM_SIZE_BIT-1:0] w_word;

    assign w_misaligned = (r_addr[1:0] != 2'b00);
    assign w_in_range   = (r_addr[31:RAM_SIZE_BIT+2] == '0);
    assign w_word       = r_addr[RAM_SIZE_BIT+1:2];

    assign read_data = r_read_data;
    assign mem_ready = r_ready;
    assign mem_error = r_error;
    assign busy      = (r_state != ST_IDLE);

    // Next-state logic: accept in IDLE, access when the wait counter hits 1
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_write || mem_read) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_count == 4'd1) begin
                    w_access     = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture and latency down-counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
        end else if (w_accept) begin
            r_count    <= 4'(LATENCY);
            r_addr     <= address;
            r_wdata    <= write_data;
            r_is_write <= mem_write;
        end else if (w_access) begin
            r_count    <= '0;
        end else if (r_state == ST_WAIT) begin
            r_count    <= r_count - 4'd1;
        end
    end

    // Completion outputs; read_data only changes on a good read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_data <= '0;
            r_ready     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_ready <= w_access;
            r_error <= w_access && w_misaligned;
            if (w_access && !r_is_write && !w_misaligned) begin
                r_read_data <= w_in_range ? r_mem[w_word] : '0;
            end
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_access && r_is_write && !w_misaligned && w_in_range) begin
            r_mem[w_word] <= r_wdata;
        end
    end

endmodule
